// File: rtl/stage_f_prefetch_pkg.sv
// Shared types and constants for the dual-ISA fetch stage.
package stage_f_prefetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    // Redirect channel indices; a higher index is a later pipeline stage.
    localparam int unsigned REDIR_RV_E  = 0;
    localparam int unsigned REDIR_ARM_E = 1;
    localparam int unsigned REDIR_ARM_W = 2;

    // One prefetch queue entry.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/stage_f_prefetch_if.sv
// Fetch-stage bus: imem request/response and the decode-facing queue head.
//  master : fetch stage (drives ImemReq/ImemAddr and the head fields)
//  slave  : memory + decode side (drives ImemRData and InstrReadyD)
interface stage_f_prefetch_if
    import stage_f_prefetch_pkg::*;
();

    logic            ImemReq;
    logic [XLEN-1:0] ImemAddr;
    logic [XLEN-1:0] ImemRData;
    logic            InstrValidD;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            InstrReadyD;
    logic            StallF;

    modport master (
        output ImemReq, ImemAddr, InstrValidD, InstrD, PCD, PCPlus4D, StallF,
        input  ImemRData, InstrReadyD
    );

    modport slave (
        input  ImemReq, ImemAddr, InstrValidD, InstrD, PCD, PCPlus4D, StallF,
        output ImemRData, InstrReadyD
    );

endinterface

// File: rtl/stage_f_prefetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with synchronous flush.
//  i_push/i_data : enqueue (ignored when full unless popping the same cycle)
//  i_pop         : dequeue head (ignored when empty)
//  i_flush       : drop all entries, reset pointers (wins over push/pop)
//  o_head        : current head entry
//  o_count       : occupancy 0..DEPTH
//  o_empty       : occupancy is zero
module stage_f_prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output T                           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/stage_f_prefetch.sv
// Fetch stage: owns PCF, issues sequential imem reads, buffers {PC, instr}
// in a prefetch queue and applies prioritised, ISA-masked redirects.
//  clk, rst      : clock, async active-low reset
//  arm           : ISA mode (0 RISC-V, 1 ARM), selects redirect mask
//  redir_valid   : per-channel redirect request
//  redir_target  : per-channel target PC, channel i at [i*XLEN +: XLEN]
//  bus           : imem request/response and decode queue head
module stage_f_prefetch
    import stage_f_prefetch_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       NREDIR    = 3,
    parameter logic [XLEN-1:0]   RESET_VEC = '0,
    parameter logic [NREDIR-1:0] RV_MASK   = NREDIR'(1 << REDIR_RV_E),
    parameter logic [NREDIR-1:0] ARM_MASK  = NREDIR'((1 << REDIR_ARM_E) | (1 << REDIR_ARM_W))
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic [NREDIR-1:0]      redir_valid,
    input  logic [NREDIR*XLEN-1:0] redir_target,
    stage_f_prefetch_if.master     bus
);

    localparam int unsigned     CW         = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]   r_pcf;
    logic [XLEN-1:0]   r_held_pc;
    logic              r_inflight;
    logic              r_drop;

    logic [NREDIR-1:0] w_eff;
    logic              w_redirect;
    logic [XLEN-1:0]   w_target;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_used;
    logic              w_empty;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;

    // Mode-masked redirect select; the loop lets the highest channel win.
    always_comb begin
        w_eff      = redir_valid & (arm ? ARM_MASK : RV_MASK);
        w_redirect = |w_eff;
        w_target   = '0;
        for (int unsigned i = 0; i < NREDIR; i++) begin
            if (w_eff[i]) w_target = redir_target[i*XLEN +: XLEN];
        end
    end

    // The in-flight request holds a queue slot, so a push can never overflow.
    assign w_used  = w_count + CW'(r_inflight);
    assign w_issue = rst && !w_redirect && (w_used < CW'(DEPTH));
    assign w_push  = r_inflight && !r_drop && !w_redirect;
    assign w_pop   = !w_empty && bus.InstrReadyD && !w_redirect;

    assign w_push_data.pc    = r_held_pc;
    assign w_push_data.instr = bus.ImemRData;

    // PCF, in-flight tracking and stale-response drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcf      <= RESET_VEC;
            r_held_pc  <= '0;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_drop     <= w_redirect && r_inflight;
            if (w_redirect) begin
                r_pcf <= w_target & ALIGN_MASK;
            end else if (w_issue) begin
                r_pcf     <= r_pcf + XLEN'(PC_STEP);
                r_held_pc <= r_pcf;
            end
        end
    end

    stage_f_prefetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign bus.ImemReq     = w_issue;
    assign bus.ImemAddr    = r_pcf;
    assign bus.InstrValidD = !w_empty;
    // Head fields read zero while the queue is empty.
    assign bus.InstrD      = w_empty ? '0 : w_head.instr;
    assign bus.PCD         = w_empty ? '0 : w_head.pc;
    assign bus.PCPlus4D    = w_empty ? '0 : w_head.pc + XLEN'(PC_STEP);
    assign bus.StallF      = (w_used >= CW'(DEPTH)) && !w_redirect;

endmodule
